// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared constants, FSM encoding and sizing helper for the nibble-serial
// carry look-ahead adder controller.
package cla_seq_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  // Encoding 2'd3 is unreachable; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle between producer, adder controller and consumer.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  // Both sides are valid/ready: a transfer occurs on a rising clk edge where
  // valid && ready; valid never waits on ready, and payload is stable while valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry look-ahead adder slice (generate/propagate form).
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per cycle,
// LSB nibble first, with the inter-slice carry held in carry_reg.
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_adder_ctrl_if.slave  bus,
  output logic                 busy,
  output state_t               dbg_state,
  output logic                 dbg_carry
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int OFF_W  = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  state_t             state_n;
  logic [IDX_W-1:0]   slice_idx;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic [OFF_W-1:0]   bit_off;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               accept;
  logic               last;

  assign bit_off = OFF_W'(int'(slice_idx) * SLICE_W);
  assign slice_a = a_reg[bit_off +: SLICE_W];
  assign slice_b = b_reg[bit_off +: SLICE_W];

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign busy          = (state == RUN) || (state == DONE);
  assign dbg_state     = state;
  assign dbg_carry     = carry_reg;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (slice_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The index holds on the last slice so it never points past the top nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slice_idx <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            slice_idx <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
          end
        end
        RUN: begin
          sum_reg[bit_off +: SLICE_W] <= slice_s;
          carry_reg                   <= slice_co;
          if (last) cout_reg  <= slice_co;
          else      slice_idx <= slice_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for the nibble-serial adder: WIDTH=16 main instance plus a
// WIDTH=4 instance, scoreboard of a+b+cin results checked on out_valid.
module tb_cla_seq_adder_ctrl;
  import cla_seq_adder_ctrl_pkg::*;

  localparam int W = 16;
  localparam int N = W / 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy16, carry16, busy4, carry4;
  state_t st16, st4;

  cla_seq_adder_ctrl_if #(.WIDTH(16)) if16 ();
  cla_seq_adder_ctrl_if #(.WIDTH(4))  if4 ();

  cla_seq_adder_ctrl #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if16),
    .busy      (busy16),
    .dbg_state (st16),
    .dbg_carry (carry16)
  );

  cla_seq_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if4),
    .busy      (busy4),
    .dbg_state (st4),
    .dbg_carry (carry4)
  );

  always #5 clk = ~clk;

  logic [W:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] ra, rb;
  logic         rc;
  logic [W:0]   e;
  int           acc, t_first, t_second, got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if16.a        = a;
    if16.b        = b;
    if16.cin      = cin;
    if16.in_valid = 1'b1;
    chk("in_ready_before_accept", if16.in_ready, 1);
    exp_q.push_back(model(a, b, cin));
    tick();
    if16.in_valid = 1'b0;
    chk("busy_after_accept", busy16, 1);
  endtask

  task automatic run_slices(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic       c;
    logic [4:0] t;
    logic [W:0] ex;
    logic [W-1:0] mask;
    c  = cin;
    ex = exp_q[0];
    for (int k = 0; k < N; k++) begin
      t    = 5'(a[4*k +: 4]) + 5'(b[4*k +: 4]) + 5'(c);
      c    = t[4];
      mask = W'((33'h1 << (4 * (k + 1))) - 33'h1);
      tick();
      chk("carry_reg", carry16, c);
      chk("partial_sum", if16.sum, ex[W-1:0] & mask);
      chk("out_valid_timing", if16.out_valid, (k == N - 1));
    end
  endtask

  task automatic finish_op(input int hold);
    logic [W:0] ex;
    ex = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("sum_hold", if16.sum, ex[W-1:0]);
      chk("cout_hold", if16.cout, ex[W]);
      chk("out_valid_hold", if16.out_valid, 1);
      chk("in_ready_hold", if16.in_ready, 0);
      tick();
    end
    chk("sum", if16.sum, ex[W-1:0]);
    chk("cout", if16.cout, ex[W]);
    chk("out_valid", if16.out_valid, 1);
    if16.out_ready = 1'b1;
    tick();
    if16.out_ready = 1'b0;
    chk("out_valid_drop", if16.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.out_ready = 1'b0;
    if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0; if4.out_ready  = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", if16.in_ready, 0);
    chk("rst_out_valid", if16.out_valid, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_sum", if16.sum, 0);
    chk("rst_cout", if16.cout, 0);
    chk("rst_state", st16, IDLE);
    chk("rst_carry", carry16, 0);
    chk("rst_state_w4", st4, IDLE);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", if16.in_ready, 1);

    accept_op(16'h1234, 16'h4321, 1'b0); run_slices(16'h1234, 16'h4321, 1'b0); finish_op(0);
    accept_op(16'hFFFF, 16'h0001, 1'b0); run_slices(16'hFFFF, 16'h0001, 1'b0); finish_op(0);
    accept_op(16'hFFFF, 16'hFFFF, 1'b1); run_slices(16'hFFFF, 16'hFFFF, 1'b1); finish_op(0);
    for (int r = 0; r < 4; r++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      accept_op(ra, rb, rc); run_slices(ra, rb, rc); finish_op(0);
    end

    // Backpressure with a new request already waiting on the input side.
    accept_op(16'h0F0F, 16'h00F1, 1'b1);
    if16.a = 16'hABCD; if16.b = 16'h1111; if16.cin = 1'b0; if16.in_valid = 1'b1;
    run_slices(16'h0F0F, 16'h00F1, 1'b1);
    finish_op(3);
    chk("busy_idle_after_hs", busy16, 0);
    accept_op(16'hABCD, 16'h1111, 1'b0); run_slices(16'hABCD, 16'h1111, 1'b0); finish_op(0);

    // Reset in the middle of RUN aborts the operation.
    accept_op(16'h7777, 16'h9999, 1'b1);
    void'(exp_q.pop_back());
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_state", st16, IDLE);
    chk("midrst_out_valid", if16.out_valid, 0);
    chk("midrst_sum", if16.sum, 0);
    chk("midrst_cout", if16.cout, 0);
    chk("midrst_busy", busy16, 0);
    chk("midrst_in_ready_low", if16.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", if16.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale_result", if16.out_valid, 0);
    end

    // Back-to-back with in_valid and out_ready tied high.
    if16.out_ready = 1'b1;
    if16.in_valid  = 1'b1;
    if16.a = 16'h8000; if16.b = 16'h8000; if16.cin = 1'b0;
    acc = 0; t_first = 0; t_second = 0;
    for (int c = 0; c < 40 && acc < 2; c++) begin
      if (if16.out_valid) begin
        chk("b2b_queue_nonempty", (exp_q.size() != 0), 1);
        e = exp_q.pop_front();
        chk("b2b_sum", if16.sum, e[W-1:0]);
        chk("b2b_cout", if16.cout, e[W]);
      end
      if (if16.in_ready) begin
        exp_q.push_back(model(if16.a, if16.b, if16.cin));
        if (acc == 0) t_first = c;
        else          t_second = c;
        acc++;
      end
      tick();
      if (acc == 1) begin
        if16.a = 16'h00FF; if16.b = 16'h0001; if16.cin = 1'b0;
      end
    end
    if16.in_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("initiation_interval", t_second - t_first, 6);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      if (if16.out_valid) got = 1;
      else tick();
    end
    chk("b2b_op2_timeout", got, 1);
    if (got == 1) begin
      e = exp_q.pop_front();
      chk("b2b_op2_sum", if16.sum, e[W-1:0]);
      chk("b2b_op2_cout", if16.cout, e[W]);
      chk("b2b_op2_sum_const", if16.sum, 16'h0100);
    end
    tick();
    if16.out_ready = 1'b0;
    chk("b2b_out_valid_drop", if16.out_valid, 0);

    // Single-slice configuration: result one cycle after accept.
    if4.a = 4'hF; if4.b = 4'h1; if4.cin = 1'b0; if4.in_valid = 1'b1;
    chk("w4_in_ready", if4.in_ready, 1);
    tick();
    if4.in_valid = 1'b0;
    chk("w4_busy", busy4, 1);
    chk("w4_out_valid_early", if4.out_valid, 0);
    tick();
    chk("w4_out_valid", if4.out_valid, 1);
    chk("w4_sum", if4.sum, 4'h0);
    chk("w4_cout", if4.cout, 1);
    chk("w4_carry", carry4, 1);
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    chk("w4_out_valid_drop", if4.out_valid, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
